// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-word layout for the pipeline stages
package pipe_pkg;
   localparam int CTRL_W        = 8;
   localparam int CTRL_REGWRITE = 7;
   localparam int CTRL_MEMTOREG = 6;
   localparam int CTRL_MEMREAD  = 5;
   localparam int CTRL_MEMWRITE = 4;
   localparam int CTRL_ALUSRC   = 3;
   localparam int CTRL_ALUOP_HI = 2;
   localparam int CTRL_ALUOP_LO = 1;
   localparam int CTRL_REGDST   = 0;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use hazard between the EX-stage load and the ID-stage instruction
// ports: ex_memread/ex_rt/ex_valid (registered EX side), id_rs/id_rt/id_uses_rt (ID side), hazard (out)
module hazard_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  ex_memread,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  ex_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   output logic                  hazard
);
   // $zero never carries a dependency, so a load into r0 cannot stall
   assign hazard = ex_valid & ex_memread & (ex_rt != '0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubble and saturating stall counter
// ports: clk_i, rst_i (sync, active-high); Control_i/PC_i/RSdata_i/RTdata_i/SignExt_i/RSaddr_i/RTaddr_i/RDaddr_i
//        from decode; Flush_i squashes the ID instruction; Stall_o holds PC and IF/ID (combinational);
//        *_o registered copies, Valid_o marks a real EX instruction, StallCnt_o counts stall cycles
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [CTRL_W-1:0]     Control_i,
   input  logic [DATA_W-1:0]     PC_i,
   input  logic [DATA_W-1:0]     RSdata_i,
   input  logic [DATA_W-1:0]     RTdata_i,
   input  logic [DATA_W-1:0]     SignExt_i,
   input  logic [REG_ADDR_W-1:0] RSaddr_i,
   input  logic [REG_ADDR_W-1:0] RTaddr_i,
   input  logic [REG_ADDR_W-1:0] RDaddr_i,
   input  logic                  Flush_i,
   output logic                  Stall_o,
   output logic [CTRL_W-1:0]     Control_o,
   output logic [DATA_W-1:0]     PC_o,
   output logic [DATA_W-1:0]     RSdata_o,
   output logic [DATA_W-1:0]     RTdata_o,
   output logic [DATA_W-1:0]     SignExt_o,
   output logic [REG_ADDR_W-1:0] RSaddr_o,
   output logic [REG_ADDR_W-1:0] RTaddr_o,
   output logic [REG_ADDR_W-1:0] RDaddr_o,
   output logic                  Valid_o,
   output logic [CNT_W-1:0]      StallCnt_o
);
   logic uses_rt, hazard, bubble;
   // rt is a source when the ALU takes it (ALUSrc=0) or when a store writes it to memory
   assign uses_rt = ~Control_i[CTRL_ALUSRC] | Control_i[CTRL_MEMWRITE];
   hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .ex_memread (Control_o[CTRL_MEMREAD]),
      .ex_rt      (RTaddr_o),
      .ex_valid   (Valid_o),
      .id_rs      (RSaddr_i),
      .id_rt      (RTaddr_i),
      .id_uses_rt (uses_rt),
      .hazard     (hazard)
   );
   // a squashed instruction never needs to wait, so flush suppresses the stall
   assign Stall_o = hazard & ~Flush_i;
   assign bubble  = Flush_i | hazard;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         Control_o  <= '0;
         PC_o       <= '0;
         RSdata_o   <= '0;
         RTdata_o   <= '0;
         SignExt_o  <= '0;
         RSaddr_o   <= '0;
         RTaddr_o   <= '0;
         RDaddr_o   <= '0;
         Valid_o    <= 1'b0;
         StallCnt_o <= '0;
      end else begin
         Control_o  <= bubble ? '0 : Control_i;
         Valid_o    <= ~bubble;
         PC_o       <= PC_i;
         RSdata_o   <= RSdata_i;
         RTdata_o   <= RTdata_i;
         SignExt_o  <= SignExt_i;
         RSaddr_o   <= RSaddr_i;
         RTaddr_o   <= RTaddr_i;
         RDaddr_o   <= RDaddr_i;
         StallCnt_o <= (Stall_o && !(&StallCnt_o)) ? StallCnt_o + 1'b1 : StallCnt_o;
      end
   end
endmodule
